// File: rtl/snd_bus_sequencer.sv
// snd_bus_sequencer: queues CPU sound-chip accesses and replays them as setup/strobe/hold bus cycles
module snd_bus_sequencer #(
  parameter int DEPTH       = 4,
  parameter int T_SETUP     = 2,
  parameter int T_YM_PULSE  = 8,
  parameter int T_SAA_PULSE = 12,
  parameter int T_HOLD      = 2
) (
  input  logic       clk32,
  input  logic       rst,
  input  logic       wr_stb,
  input  logic [1:0] wr_target,
  input  logic       wr_a0,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic [1:0] rd_target,
  input  logic       rd_a0,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       wait_req,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic       busy,
  output logic       bus_a0,
  output logic [7:0] bus_d,
  output logic       bus_d_oe,
  input  logic [7:0] bus_din,
  output logic       bus_n_wr,
  output logic       bus_n_rd,
  output logic       n_ym1_cs,
  output logic       n_ym2_cs,
  output logic       n_saa_cs
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t state_q, state_d;
  logic [10:0] mem_q [DEPTH];
  logic [10:0] head;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [3:0] tmr_q, tmr_d;
  logic [1:0] tgt_q, tgt_d;
  logic a0_q, a0_d, rd_q, rd_d;
  logic [7:0] dat_q, dat_d, rdd_q, rdd_d, bd_q, bd_d;
  logic ovf_q, ovf_d, wait_q, wait_d, rdv_q, rdv_d, done_q, done_d;
  logic [2:0] ncs_q, ncs_d;
  logic nwr_q, nwr_d, nrd_q, nrd_d, oe_q, oe_d, ba0_q, ba0_d;
  logic push, pop, act;
  assign head = mem_q[rp_q];
  assign push = wr_stb && (fill_q < CW'(DEPTH));
  // state register plus all registered bus and status outputs
  always_ff @(posedge clk32) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      fill_q  <= '0;
      tmr_q   <= '0;
      tgt_q   <= '0;
      a0_q    <= 1'b0;
      rd_q    <= 1'b0;
      dat_q   <= '0;
      rdd_q   <= 8'hFF;
      ovf_q   <= 1'b0;
      wait_q  <= 1'b0;
      rdv_q   <= 1'b0;
      done_q  <= 1'b0;
      ncs_q   <= 3'b111;
      nwr_q   <= 1'b1;
      nrd_q   <= 1'b1;
      oe_q    <= 1'b0;
      bd_q    <= '0;
      ba0_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fill_q  <= fill_d;
      tmr_q   <= tmr_d;
      tgt_q   <= tgt_d;
      a0_q    <= a0_d;
      rd_q    <= rd_d;
      dat_q   <= dat_d;
      rdd_q   <= rdd_d;
      ovf_q   <= ovf_d;
      wait_q  <= wait_d;
      rdv_q   <= rdv_d;
      done_q  <= done_d;
      ncs_q   <= ncs_d;
      nwr_q   <= nwr_d;
      nrd_q   <= nrd_d;
      oe_q    <= oe_d;
      bd_q    <= bd_d;
      ba0_q   <= ba0_d;
    end
  end
  // write FIFO storage; contents need no reset since pointers and fill are cleared
  always_ff @(posedge clk32) begin
    if (push) mem_q[wp_q] <= {wr_target, wr_a0, wr_data};
  end
  // next-state: writes have priority over reads, one shared down-counter times every phase
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q - 4'd1;
    tgt_d   = tgt_q;
    a0_d    = a0_q;
    dat_d   = dat_q;
    rd_d    = rd_q;
    rdd_d   = rdd_q;
    rdv_d   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = 4'(T_SETUP - 1);
        if (fill_q != '0) begin
          pop = 1'b1;
          {tgt_d, a0_d, dat_d} = head;
          rd_d = 1'b0;
          if (head[10:9] != 2'd3) state_d = SETUP;
        end else if (rd_req && !done_q) begin
          if (rd_target[1]) begin
            rdv_d = 1'b1;
            rdd_d = 8'hFF;
          end else begin
            state_d = SETUP;
            tgt_d   = rd_target;
            a0_d    = rd_a0;
            rd_d    = 1'b1;
          end
        end
      end
      SETUP: if (tmr_q == 4'd0) begin
        state_d = STROBE;
        tmr_d   = 4'((tgt_q == 2'd2) ? T_SAA_PULSE - 1 : T_YM_PULSE - 1);
      end
      STROBE: if (tmr_q == 4'd0) begin
        state_d = HOLD;
        tmr_d   = 4'(T_HOLD - 1);
        rdd_d   = rd_q ? bus_din : rdd_q;
      end
      default: if (tmr_q == 4'd0) begin
        state_d = IDLE;
        rdv_d   = rd_q;
      end
    endcase
  end
  // FIFO bookkeeping, sticky overflow, read handshake and registered wait request
  always_comb begin
    wp_d   = push ? ((wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d   = pop ? ((rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1) : rp_q;
    fill_d = fill_q + CW'(push) - CW'(pop);
    ovf_d  = (wr_stb && !push) || (ovf_q && !ovf_clr);
    done_d = rdv_d || (done_q && rd_req);
    wait_d = (fill_q >= CW'(DEPTH - 1)) || (rd_req && !done_q);
  end
  // bus outputs decoded from the next state so every pin comes straight from a flop
  always_comb begin
    act   = state_d != IDLE;
    ncs_d = {~(act && tgt_d == 2'd2), ~(act && tgt_d == 2'd1), ~(act && tgt_d == 2'd0)};
    nwr_d = ~(state_d == STROBE && !rd_d);
    nrd_d = ~(state_d == STROBE && rd_d);
    oe_d  = act && !rd_d;
    bd_d  = oe_d ? dat_d : bd_q;
    ba0_d = act ? a0_d : ba0_q;
  end
  assign rd_data  = rdd_q;
  assign rd_valid = rdv_q;
  assign wait_req = wait_q;
  assign ovf      = ovf_q;
  assign busy     = (fill_q != '0) || (state_q != IDLE);
  assign bus_a0   = ba0_q;
  assign bus_d    = bd_q;
  assign bus_d_oe = oe_q;
  assign bus_n_wr = nwr_q;
  assign bus_n_rd = nrd_q;
  assign n_ym1_cs = ncs_q[0];
  assign n_ym2_cs = ncs_q[1];
  assign n_saa_cs = ncs_q[2];
endmodule

// File: tb/tb_snd_bus_sequencer.sv
// tb_snd_bus_sequencer: random traffic checked cycle by cycle against a transaction timeline model
module tb_snd_bus_sequencer;
  localparam int DEPTH = 4, TS = 2, TY = 8, TSA = 12, TH = 2;
  localparam int N_RAND = 6000, NR = 6300, N_END = 6380, NCYC = 6400;
  logic clk32 = 1'b0;
  logic rst = 1'b1;
  logic wr_stb = 1'b0;
  logic [1:0] wr_target = '0;
  logic wr_a0 = 1'b0;
  logic [7:0] wr_data = '0;
  logic rd_req = 1'b0;
  logic [1:0] rd_target = '0;
  logic rd_a0 = 1'b0;
  logic ovf_clr = 1'b0;
  logic [7:0] bus_din = '0;
  logic [7:0] rd_data, bus_d;
  logic rd_valid, wait_req, ovf, busy, bus_a0, bus_d_oe, bus_n_wr, bus_n_rd;
  logic n_ym1_cs, n_ym2_cs, n_saa_cs;
  snd_bus_sequencer #(.DEPTH(DEPTH), .T_SETUP(TS), .T_YM_PULSE(TY), .T_SAA_PULSE(TSA), .T_HOLD(TH)) dut (
    .clk32(clk32), .rst(rst), .wr_stb(wr_stb), .wr_target(wr_target), .wr_a0(wr_a0),
    .wr_data(wr_data), .rd_req(rd_req), .rd_target(rd_target), .rd_a0(rd_a0),
    .rd_data(rd_data), .rd_valid(rd_valid), .wait_req(wait_req), .ovf(ovf), .ovf_clr(ovf_clr),
    .busy(busy), .bus_a0(bus_a0), .bus_d(bus_d), .bus_d_oe(bus_d_oe), .bus_din(bus_din),
    .bus_n_wr(bus_n_wr), .bus_n_rd(bus_n_rd), .n_ym1_cs(n_ym1_cs), .n_ym2_cs(n_ym2_cs),
    .n_saa_cs(n_saa_cs));
  always #5 clk32 = ~clk32;
  typedef struct {
    bit rd;
    int tgt;
    bit a0;
    logic [7:0] d;
    int push;
    int pop;
    int dur;
  } ent_t;
  ent_t q[$];
  int cyc, vecs, errs, last_end, last_v, rd_r, rd_end, rd_p, rate, rst_at;
  bit ovf_m, drop;
  logic [7:0] din_h [NCYC];
  bit rdreq_h [NCYC];
  int rates [4] = '{3, 10, 30, 60};
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  function automatic int pulse_of(int tgt);
    return (tgt == 2) ? TSA : TY;
  endfunction
  function automatic int dur_of(bit rd, int tgt);
    if (rd) return (tgt < 2) ? 1 + TS + TY + TH : 1;
    return (tgt == 3) ? 1 : 1 + TS + pulse_of(tgt) + TH;
  endfunction
  function automatic int occ(int c);
    int n = 0;
    for (int i = 0; i < q.size(); i++)
      if (!q[i].rd && q[i].push < c && q[i].pop >= c) n++;
    return n;
  endfunction
  task automatic check_cycle();
    int ai, k, t;
    bit bsy, vld, stb;
    logic [7:0] vd;
    logic [2:0] ecs;
    logic ewr, erd, eoe;
    while (q.size() > 0 && q[0].pop + q[0].dur + 2 < cyc) void'(q.pop_front());
    ai = -1; bsy = 0; vld = 0; vd = 8'hFF;
    ecs = 3'b111; ewr = 1; erd = 1; eoe = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].pop < cyc && cyc < q[i].pop + q[i].dur) begin ai = i; bsy = 1; end
      if (!q[i].rd && q[i].push < cyc && cyc <= q[i].pop) bsy = 1;
      if (q[i].rd && q[i].pop + q[i].dur == cyc) begin
        vld = 1;
        vd = (q[i].tgt < 2) ? din_h[q[i].pop + TS + TY] : 8'hFF;
      end
    end
    if (ai >= 0) begin
      t = q[ai].tgt;
      k = cyc - q[ai].pop - 1;
      stb = (k >= TS) && (k < TS + pulse_of(t));
      ecs[t] = 1'b0;
      ewr = !(stb && !q[ai].rd);
      erd = !(stb && q[ai].rd);
      eoe = !q[ai].rd;
      check_eq("bus_a0", {7'd0, bus_a0}, {7'd0, q[ai].a0});
      if (!q[ai].rd) check_eq("bus_d", bus_d, q[ai].d);
    end
    check_eq("cs", {5'd0, n_saa_cs, n_ym2_cs, n_ym1_cs}, {5'd0, ecs});
    check_eq("n_wr", {7'd0, bus_n_wr}, {7'd0, ewr});
    check_eq("n_rd", {7'd0, bus_n_rd}, {7'd0, erd});
    check_eq("d_oe", {7'd0, bus_d_oe}, {7'd0, eoe});
    check_eq("busy", {7'd0, busy}, {7'd0, bsy});
    check_eq("wait_req", {7'd0, wait_req}, {7'd0, (occ(cyc - 1) >= DEPTH - 1) || rdreq_h[cyc - 1]});
    check_eq("ovf", {7'd0, ovf}, {7'd0, ovf_m});
    check_eq("rd_valid", {7'd0, rd_valid}, {7'd0, vld});
    if (vld) check_eq("rd_data", rd_data, vd);
    if (cyc == 2) begin
      check_eq("rst_rd_data", rd_data, 8'hFF);
      check_eq("rst_bus_d", bus_d, 8'h00);
      check_eq("rst_bus_a0", {7'd0, bus_a0}, 8'h00);
    end
  endtask
  task automatic do_write(input int tgt, input int a0, input int d);
    ent_t e;
    wr_stb = 1'b1;
    wr_target = 2'(tgt);
    wr_a0 = 1'(a0);
    wr_data = 8'(d);
    if (occ(cyc) < DEPTH) begin
      e.rd = 0; e.tgt = tgt; e.a0 = 1'(a0); e.d = 8'(d); e.push = cyc;
      e.pop = (cyc + 1 > last_end) ? cyc + 1 : last_end;
      e.dur = dur_of(0, tgt);
      q.push_back(e);
      last_end = e.pop + e.dur;
      if (cyc == NR) rst_at = e.pop + TS + 3;
    end else drop = 1;
  endtask
  task automatic start_read(input int tgt, input int a0, input bit early);
    ent_t e;
    rd_target = 2'(tgt);
    rd_a0 = 1'(a0);
    e.rd = 1; e.tgt = tgt; e.a0 = 1'(a0); e.d = 8'h00; e.push = cyc - 1;
    e.pop = (cyc > last_end) ? cyc : last_end;
    e.dur = dur_of(1, tgt);
    q.push_back(e);
    last_end = e.pop + e.dur;
    last_v = last_end;
    rd_r = cyc;
    rd_p = e.pop;
    rd_end = (early && tgt < 2) ? e.pop + 2 : last_v;
  endtask
  task automatic drive();
    wr_stb = 1'b0;
    ovf_clr = 1'b0;
    drop = 0;
    rst = (cyc < 3) || (cyc == rst_at);
    bus_din = 8'($urandom);
    din_h[cyc] = bus_din;
    if (cyc == 5) do_write(0, 1, 8'h5A);
    else if (cyc >= 30 && cyc < N_RAND) begin
      if (cyc % 150 == 0) rate = rates[$urandom_range(0, 3)];
      if (cyc > last_v && $urandom_range(0, 59) == 0)
        start_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      if (cyc >= rd_p && int'($urandom_range(0, 99)) < rate)
        do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
      ovf_clr = ($urandom_range(0, 24) == 0);
    end else if (cyc >= NR && cyc < NR + 3) do_write(0, cyc % 2, 8'hA0 + cyc - NR);
    rd_req = (cyc >= rd_r) && (cyc < rd_end);
    rdreq_h[cyc] = rd_req;
    ovf_m = rst ? 1'b0 : (drop || (ovf_m && !ovf_clr));
    if (rst) begin
      q.delete();
      last_end = 0;
      rd_end = 0;
      rd_p = 0;
      last_v = cyc;
    end
  endtask
  initial begin
    vecs = 0; errs = 0; last_end = 0; last_v = 0; rd_r = 0; rd_end = 0; rd_p = 0;
    rate = 10; rst_at = -1; ovf_m = 0;
    for (int c = 0; c <= N_END; c++) begin
      @(negedge clk32);
      cyc = c;
      if (c > 0) check_cycle();
      drive();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
